// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: iterative double-dabble binary-to-BCD converter, one bit per clock
// Ports: CLK/RST (sync, active-high) | START+BIN request (IDLE only) | BUSY while shifting,
//        DONE one-cycle pulse | BCD held result (digit 0 in [3:0]) | BLANK leading-zero mask.
// Option: define BCD_LEADING_BLANK_EN to register BLANK alongside BCD; otherwise BLANK is 0.
module bcd_convert_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BIN_WIDTH-1:0]  BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     BLANK
);
  localparam int SW = 4*DIGITS + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_sr, w_corr, w_shift;
  logic [CW-1:0] r_cnt;
  logic [4*DIGITS-1:0] r_bcd;
  logic w_last;
  // one shared bank of add-3 cells, reused on every iteration; no carry between digits
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign w_corr[BIN_WIDTH+4*d +: 4] = (r_sr[BIN_WIDTH+4*d +: 4] >= 4'd5) ?
                                        r_sr[BIN_WIDTH+4*d +: 4] + 4'd3 :
                                        r_sr[BIN_WIDTH+4*d +: 4];
  end
  assign w_corr[BIN_WIDTH-1:0] = r_sr[BIN_WIDTH-1:0];
  assign w_shift = w_corr << 1;
  assign w_last  = r_cnt == CW'(BIN_WIDTH - 1);
  always_ff @(posedge CLK)
    r_state <= RST ? S_IDLE : w_next;
  always_comb
    w_next = (r_state == S_IDLE)  ? (START  ? S_SHIFT : S_IDLE)  :
             (r_state == S_SHIFT) ? (w_last ? S_FIN   : S_SHIFT) : S_IDLE;
  always_comb begin
    BUSY = r_state == S_SHIFT;
    DONE = r_state == S_FIN;
  end
  // BCD is captured on the edge entering FIN so it is already valid while DONE is high
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
    end else if (r_state == S_IDLE && START) begin
      r_sr  <= {{4*DIGITS{1'b0}}, BIN};
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sr  <= w_shift;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_bcd <= w_shift[SW-1 -: 4*DIGITS];
    end
  end
  assign BCD = r_bcd;
`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] r_blank, w_blank;
  // digit 0 is never blanked so a zero value still shows one "0"
  always_comb begin : blank_calc
    logic z;
    w_blank = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (w_shift[BIN_WIDTH+4*i +: 4] == 4'd0);
      w_blank[i] = z;
    end
  end
  always_ff @(posedge CLK)
    if (RST) r_blank <= '0;
    else if (r_state == S_SHIFT && w_last) r_blank <= w_blank;
  assign BLANK = r_blank;
`else
  assign BLANK = '0;
`endif
endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Iterative binary-to-BCD converter for the LED counter display path.
- Runs the shift-and-add-3 (double-dabble) algorithm one bit per clock, sharing one bank of per-digit add-3 correction cells across all iterations.
- Sequences the correction/shift steps and exposes a START/BUSY/DONE handshake to the counter logic.
- Holds the last converted result stable for the display drivers.

Parameters:
- BIN_WIDTH, 16, width of the binary input; also the number of shift iterations.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_WIDTH-1; the 16/5 default meets this.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a conversion of BIN; accepted only in IDLE.
- BIN  input  BIN_WIDTH  binary value; sampled on the accepting edge only.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  single-cycle pulse; BCD is valid from this cycle.
- BCD  output  4*DIGITS  packed result; digit 0 (ones) in [3:0].
- BLANK  output  DIGITS  leading-zero mask (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock domain, CLK.
  - Reset is synchronous, active-high on RST.
- Reset values:
  - State = IDLE; BUSY=0, DONE=0, BCD=0, BLANK=0.
  - Internal shift register and iteration counter cleared.
- State IDLE:
  - START=1 at edge k: load shift register = {4*DIGITS zeros, BIN}, counter=0, go to SHIFT.
  - BUSY=1 from cycle k+1.
- State SHIFT, one iteration per cycle:
  - Each BCD digit field that is >=5 gets +3, computed as 4-bit arithmetic with no carry into the next digit.
  - The corrected {BCD field, binary field} is then shifted left by 1.
  - Counter increments.
  - After the BIN_WIDTH-th iteration, go to FIN.
- State FIN (one cycle):
  - BCD register loaded from the shift register's BCD field.
  - DONE=1 and BUSY=0 in this cycle; next state is IDLE.
- Latency:
  - START accepted at edge k → DONE high in cycle k+BIN_WIDTH+1, i.e. cycle 17 for the default.
  - Throughput: one conversion per BIN_WIDTH+2 cycles.
- Handshake rules:
  - START while BUSY or in FIN is ignored; no queueing.
  - BIN changes after the accepting edge do not affect the running conversion.
  - The BCD output changes only in FIN; it holds the previous result throughout SHIFT.
- Arithmetic:
  - The correction is the 10-entry add-3 table: 0-4 unchanged, 5-9 → 8-12.
  - Field values >9 never occur when the DIGITS parameter is legal.
  - Counter width is clog2(BIN_WIDTH+1).
- Boundaries:
  - BIN=0 yields all-zero BCD after the full latency; there is no early exit.
  - BIN=2^BIN_WIDTH-1 yields the exact decimal value with no truncation.
- Reset mid-operation: RST high in any state aborts the conversion next edge. BUSY, DONE and BCD all clear; no DONE pulse is issued for the aborted conversion.
- Simultaneous RST and START: RST wins; START is ignored.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: BLANK is registered alongside BCD in FIN.
  - BLANK[i]=1 when digit i and every higher digit are zero, for i>=1.
  - BLANK[0] is always 0, so a value of 0 displays a single "0".
  - BLANK clears on reset.
- Undefined: BLANK is tied to all zeros and no blanking logic is synthesized.
- BCD output and timing are identical in both builds.

Test Plan:
- Reset, then START with BIN=16'd0 → DONE pulse exactly 17 cycles after the accepting edge, BCD=20'h00000; with BCD_LEADING_BLANK_EN, BLANK=5'b11110.
- BIN=16'd65535 → BCD=20'h65535; BLANK=5'b00000.
- BIN=16'd1234, then BIN changed to 16'd9999 during SHIFT → BCD=20'h01234. BUSY is high for 16 cycles, and BCD holds the prior result until FIN.
- START re-asserted every cycle during BUSY and in the FIN cycle → exactly one DONE pulse per accepted START. The next START, accepted in IDLE, converts BIN=16'd9 to 20'h00009.
- RST asserted at iteration 8 of BIN=16'd4321 → next cycle BUSY=0 and BCD=0, with no DONE pulse. A new START with BIN=16'd42 gives 20'h00042 with full latency.
